arith_operand_feeder: RTL and testbench
=======================================

Name: arith_operand_feeder

Overview:
- Upstream/downstream wrapper stage for the 8-bit combinational arithmetic unit (sum, shift, compare, XOR-reduce).
- Accepts a byte stream over a valid/ready handshake: first byte is operand A, second is operand B.
- Drives both operands to the arithmetic unit as registered values, waits a fixed settle time, then captures the unit's results.
- Presents the captured results as one record on a valid/ready output handshake and counts completed pairs.

Parameters:
- SETTLE_CYCLES, 1: cycles the operands are held before results are sampled; legal range 1..15.
- CNT_W, 16: width of the completed-pair counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  feeder can accept a byte this cycle.
- ina  out  8  registered operand A to the arithmetic unit.
- inb  out  8  registered operand B to the arithmetic unit.
- res_sumab  in  9  unit sum, including carry in bit 8.
- res_sumflag  in  1  unit carry flag.
- res_shift  in  8  unit result A shifted left by B.
- res_less  in  1  unit A<B flag.
- res_equal  in  1  unit A==B flag.
- res_xor  in  1  unit XOR-reduce of A.
- out_sumab  out  9  captured sum.
- out_shift  out  8  captured shift result.
- out_flags  out  4  captured flags as {sumflag, less, equal, xor}, in that order MSB..LSB.
- out_valid  out  1  result record is valid.
- out_ready  in  1  consumer accepts the record.
- pair_cnt  out  CNT_W  count of records accepted downstream.
- busy  out  1  high in every state except S_A.

Behaviour:
- Reset: state goes to S_A, all output registers clear, and the abort takes effect immediately in any state.
  - ina, inb, out_sumab, out_shift, out_flags, pair_cnt, and the settle counter clear to 0.
  - out_valid = 0; in_ready = 1 (state S_A); busy = 0.
  - Any partially loaded pair or pending result is discarded.
- FSM states are S_A, S_B, S_SETTLE and S_OUT.
  - in_ready = 1 in S_A and S_B only, decoded from state.
  - out_valid = 1 in S_OUT only, registered.
- S_A: on in_valid&&in_ready, ina <= in_data and the FSM moves to S_B. inb keeps its old value.
- S_B: on in_valid&&in_ready, inb <= in_data, the settle counter loads 0, and the FSM moves to S_SETTLE.
- S_SETTLE:
  - The counter increments each cycle.
  - In the cycle where counter == SETTLE_CYCLES-1, at the edge:
    - out_sumab, out_shift and out_flags are sampled from the res_* inputs;
    - out_valid <= 1; the FSM moves to S_OUT.
  - ina and inb are stable throughout S_SETTLE and S_OUT.
- S_OUT: on out_valid&&out_ready:
  - out_valid <= 0; pair_cnt increments;
  - the FSM moves to S_A, so in_ready is high in the next cycle. There is no same-cycle bypass.
- Backpressure: while out_valid=1 and out_ready=0, every out_* register and pair_cnt hold their values.
- Latency: if B is accepted at edge N, results are captured and out_valid rises at edge N+SETTLE_CYCLES.
- pair_cnt wraps from all-ones to 0 with no flag.
- in_valid is ignored in S_SETTLE and S_OUT; in_data is not consumed.
- Throughput: at most one pair per (2 + SETTLE_CYCLES + 1) cycles.
- No arithmetic is performed internally; res_* values are captured bit-exact.

Test Plan:
- Reset then idle:
  - Required: in_ready=1, out_valid=0, ina=inb=0, pair_cnt=0, busy=0.
- Send A=0xFF, B=0x01 with out_ready=1, arithmetic unit attached, SETTLE_CYCLES=1:
  - out_valid rises 1 cycle after B is accepted.
  - out_sumab=0x100, out_flags=4'b1000, out_shift=0xFE.
  - pair_cnt=1.
- Send A=0x05, B=0x05, with out_ready held 0 for 5 cycles:
  - out_valid stays 1 and out_flags=4'b0010 stays stable.
  - in_ready=0 throughout; no pair_cnt change until out_ready=1.
- Send A=0x03, B=0x09:
  - out_shift=0x00, out_flags=4'b0100, out_sumab=0x00C.
- Mid-operation reset:
  - Send A=0x12 then deassert rst_n asynchronously before B.
  - Required: outputs clear immediately and state is S_A.
  - Next pair 0x02, 0x03 gives out_sumab=0x005 (stale A discarded).
- SETTLE_CYCLES=4 with in_valid held high during S_SETTLE:
  - Exactly 2 bytes consumed per pair.
  - out_valid rises 4 cycles after B is accepted.
- Force pair_cnt to 16'hFFFF via back-to-back pairs, then complete one more:
  - Required: pair_cnt=0.

Source files
------------

// File: rtl/arith_operand_feeder.sv
// Operand feeder around an 8-bit combinational arithmetic unit: loads A then B,
// holds them for SETTLE_CYCLES, captures the unit's results into one output record.
module arith_operand_feeder #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       ina,
  output logic [7:0]       inb,
  input  logic [8:0]       res_sumab,
  input  logic             res_sumflag,
  input  logic [7:0]       res_shift,
  input  logic             res_less,
  input  logic             res_equal,
  input  logic             res_xor,
  output logic [8:0]       out_sumab,
  output logic [7:0]       out_shift,
  output logic [3:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {S_A, S_B, S_SETTLE, S_OUT} state_t;

  typedef struct packed {
    logic [8:0] sumab;
    logic [7:0] shift;
    logic [3:0] flags;
  } rec_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  rec_t       rec;
  logic       in_fire, out_fire, settle_done;

  assign in_ready    = (state == S_A) || (state == S_B);
  assign busy        = (state != S_A);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign settle_done = (settle_cnt == 4'(SETTLE_CYCLES - 1));

  assign out_sumab = rec.sumab;
  assign out_shift = rec.shift;
  assign out_flags = rec.flags;

  always_comb begin
    state_nxt = state;
    case (state)
      S_A:      if (in_fire)     state_nxt = S_B;
      S_B:      if (in_fire)     state_nxt = S_SETTLE;
      S_SETTLE: if (settle_done) state_nxt = S_OUT;
      S_OUT:    if (out_fire)    state_nxt = S_A;
      default:                   state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_A;
    else        state <= state_nxt;
  end

  // Operands only change while loading, so the unit sees stable inputs through settle/output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ina        <= '0;
      inb        <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == S_A && in_fire) ina <= in_data;
      if (state == S_B && in_fire) begin
        inb        <= in_data;
        settle_cnt <= '0;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec       <= '0;
      out_valid <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      if (state == S_SETTLE && settle_done) begin
        rec       <= '{sumab: res_sumab, shift: res_shift,
                       flags: {res_sumflag, res_less, res_equal, res_xor}};
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        pair_cnt  <= pair_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arith_operand_feeder.sv
// Scoreboard bench: two feeders (settle 1 / 16-bit count, settle 4 / 3-bit count)
// driven with random operand pairs against a plain-arithmetic reference model.
module tb_arith_operand_feeder;

  typedef struct packed {
    logic [8:0] sum;
    logic [7:0] shift;
    logic [3:0] flags;
  } rec_t;

  typedef struct {
    rec_t r;
    int   at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n [2];
  logic [7:0] in_data [2];
  logic       in_valid [2], in_ready [2], out_valid [2], out_ready [2], busy [2];
  logic       res_sumflag [2], res_less [2], res_equal [2], res_xor [2];
  logic [7:0] ina [2], inb [2], res_shift [2], out_shift [2];
  logic [8:0] res_sumab [2], out_sumab [2];
  logic [3:0] out_flags [2];
  logic [15:0] pair_cnt0;
  logic [2:0]  pair_cnt1;

  int   errors = 0, checks = 0;
  exp_t sbq [2][$];
  logic [7:0] ina_m [2], inb_m [2];
  bit   pending [2], a_loaded [2], hold [2], rnd_or [2];
  int   exp_cnt [2];
  rec_t last [2];

  arith_operand_feeder #(.SETTLE_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ina(ina[0]), .inb(inb[0]), .res_sumab(res_sumab[0]),
    .res_sumflag(res_sumflag[0]), .res_shift(res_shift[0]), .res_less(res_less[0]),
    .res_equal(res_equal[0]), .res_xor(res_xor[0]), .out_sumab(out_sumab[0]),
    .out_shift(out_shift[0]), .out_flags(out_flags[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .pair_cnt(pair_cnt0), .busy(busy[0]));

  arith_operand_feeder #(.SETTLE_CYCLES(4), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ina(ina[1]), .inb(inb[1]), .res_sumab(res_sumab[1]),
    .res_sumflag(res_sumflag[1]), .res_shift(res_shift[1]), .res_less(res_less[1]),
    .res_equal(res_equal[1]), .res_xor(res_xor[1]), .out_sumab(out_sumab[1]),
    .out_shift(out_shift[1]), .out_flags(out_flags[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .pair_cnt(pair_cnt1), .busy(busy[1]));

  // Combinational arithmetic unit attached to each feeder.
  for (genvar g = 0; g < 2; g++) begin : g_unit
    assign res_sumab[g]   = 9'(ina[g]) + 9'(inb[g]);
    assign res_sumflag[g] = res_sumab[g][8];
    assign res_shift[g]   = 8'(ina[g] << inb[g]);
    assign res_less[g]    = ina[g] < inb[g];
    assign res_equal[g]   = ina[g] == inb[g];
    assign res_xor[g]     = ^ina[g];
  end

  function automatic int settle(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic rec_t model(input logic [7:0] a, input logic [7:0] b);
    int   s, p;
    rec_t r;
    s = int'(a) + int'(b);
    p = (b >= 8) ? 0 : (int'(a) * (1 << b)) % 256;
    r.sum   = 9'(s);
    r.shift = 8'(p);
    r.flags = {s > 255, a < b, a == b, ($countones(a) % 2) == 1};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    ina_m[d] = 0; inb_m[d] = 0; pending[d] = 0; a_loaded[d] = 0; exp_cnt[d] = 0;
    sbq[d].delete();
  endtask

  task automatic send_byte(input int d, input logic [7:0] v, input bit isb);
    int   n;
    exp_t e;
    n = 0;
    in_data[d] = v; in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && n < 100) begin @(negedge clk); n++; end
    if (!in_ready[d]) begin
      chk("in_ready_timeout", 32'(in_ready[d]), 32'd1);
      in_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (isb) begin
      inb_m[d] = v; a_loaded[d] = 0; pending[d] = 1;
      e.r = model(ina_m[d], v); e.at = cyc;
      sbq[d].push_back(e);
    end else begin
      ina_m[d] = v; a_loaded[d] = 1;
    end
    if (hold[d]) in_data[d] = 8'($urandom);
    else         in_valid[d] = 1'b0;
  endtask

  task automatic send_pair(input int d, input logic [7:0] a, input logic [7:0] b);
    send_byte(d, a, 1'b0);
    send_byte(d, b, 1'b1);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (pending[d] && n < 300) begin @(negedge clk); n++; end
    if (pending[d]) chk("drain_timeout", 32'(pending[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: protocol/state checks every cycle and scoreboard pop on each accepted record.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit   ov_exp;
      exp_t h;
      chk("in_ready", 32'(in_ready[d]), 32'(!pending[d]));
      chk("busy", 32'(busy[d]), 32'(pending[d] || a_loaded[d]));
      chk("ina", 32'(ina[d]), 32'(ina_m[d]));
      chk("inb", 32'(inb[d]), 32'(inb_m[d]));
      if (d == 0) chk("pair_cnt0", 32'(pair_cnt0), exp_cnt[0] & 32'hFFFF);
      else        chk("pair_cnt1", 32'(pair_cnt1), exp_cnt[1] & 32'h7);
      ov_exp = 0;
      if (pending[d] && sbq[d].size() > 0) begin
        h = sbq[d][0];
        ov_exp = (cyc >= h.at + settle(d));
      end
      chk("out_valid", 32'(out_valid[d]), 32'(ov_exp));
      if (out_valid[d] && sbq[d].size() > 0) begin
        h = sbq[d][0];
        chk("out_sumab", 32'(out_sumab[d]), 32'(h.r.sum));
        chk("out_shift", 32'(out_shift[d]), 32'(h.r.shift));
        chk("out_flags", 32'(out_flags[d]), 32'(h.r.flags));
        if (out_ready[d]) begin
          void'(sbq[d].pop_front());
          last[d] = '{sum: out_sumab[d], shift: out_shift[d], flags: out_flags[d]};
          exp_cnt[d]++;
          pending[d] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) if (rnd_or[d]) out_ready[d] = 1'($urandom % 2);
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_data[d] = 0; in_valid[d] = 0; out_ready[d] = 1'b1;
      hold[d] = 0; rnd_or[d] = 0; model_reset(d);
    end
    #1;
    chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_ina_inb", 32'({ina[0], inb[0]}), 32'd0);
    chk("rst_pair_cnt", 32'(pair_cnt0), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    #11;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Carry / shift vector.
    send_pair(0, 8'hFF, 8'h01);
    wait_idle(0);
    chk("ff01_sum", 32'(last[0].sum), 32'h100);
    chk("ff01_flags", 32'(last[0].flags), 32'b1000);
    chk("ff01_shift", 32'(last[0].shift), 32'hFE);
    chk("ff01_cnt", 32'(pair_cnt0), 32'd1);

    // Equal operands under backpressure.
    out_ready[0] = 1'b0;
    send_pair(0, 8'h05, 8'h05);
    repeat (2) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_flags", 32'(out_flags[0]), 32'b0010);
      chk("bp_cnt", 32'(pair_cnt0), 32'd1);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_idle(0);
    chk("bp_cnt_after", 32'(pair_cnt0), 32'd2);

    // Oversized shift amount.
    send_pair(0, 8'h03, 8'h09);
    wait_idle(0);
    chk("0309_shift", 32'(last[0].shift), 32'h00);
    chk("0309_flags", 32'(last[0].flags), 32'b0100);
    chk("0309_sum", 32'(last[0].sum), 32'h00C);

    // Random traffic with random backpressure.
    rnd_or[0] = 1;
    for (int i = 0; i < 20; i++) send_pair(0, 8'($urandom), 8'($urandom));
    wait_idle(0);
    rnd_or[0] = 0; out_ready[0] = 1'b1;
    wait_idle(0);

    // Abort after A: stale operand must be discarded.
    send_byte(0, 8'h12, 1'b0);
    @(posedge clk); #2;
    rst_n[0] = 1'b0;
    model_reset(0);
    #1;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_ina", 32'(ina[0]), 32'd0);
    chk("abort_cnt", 32'(pair_cnt0), 32'd0);
    chk("abort_out", 32'({out_sumab[0], out_shift[0], out_flags[0]}), 32'd0);
    @(negedge clk); #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    send_pair(0, 8'h02, 8'h03);
    wait_idle(0);
    chk("abort_next_sum", 32'(last[0].sum), 32'h005);

    // Settle 4 with in_valid held high throughout.
    hold[1] = 1;
    for (int i = 0; i < 6; i++) send_pair(1, 8'($urandom), 8'($urandom));
    hold[1] = 0; in_valid[1] = 1'b0;
    wait_idle(1);
    chk("hold_cnt", 32'(pair_cnt1), 32'd6);

    // Counter wrap on the narrow counter.
    @(posedge clk); #2;
    rst_n[1] = 1'b0;
    model_reset(1);
    @(negedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) send_pair(1, 8'($urandom), 8'($urandom));
    wait_idle(1);
    chk("wrap_full", 32'(pair_cnt1), 32'd7);
    send_pair(1, 8'h80, 8'h7F);
    wait_idle(1);
    chk("wrap_zero", 32'(pair_cnt1), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_empty0", 32'(sbq[0].size()), 32'd0);
    chk("sb_empty1", 32'(sbq[1].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
